// File: rtl/pwm_demod_pkg.sv
// -----------------------------------------------------------------------------
// pwm_demod_pkg
// Shared audio-path definitions used by the PWM transmitter and receiver.
//   PWM_PERIOD : clocks per PWM frame (transmitter counter wraps at 254)
//   SAMPLE_W   : audio sample width
//   state_t    : receiver alignment state
//   sat_max()  : largest value representable in a given number of bits
// -----------------------------------------------------------------------------
package pwm_demod_pkg;

  localparam int PWM_PERIOD = 255;
  localparam int SAMPLE_W   = 8;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_demod_if.sv
// -----------------------------------------------------------------------------
// pwm_demod_if
// Signal bundle between a PWM source / sample consumer and the demodulator.
//   pwm_in       : asynchronous PWM stream (source -> demod)
//   sample_out   : last recovered sample (demod -> consumer)
//   sample_valid : one-cycle pulse when sample_out updates
//   locked       : frame alignment established
//   frame_err    : one-cycle pulse on a short frame (optional check)
// Modports: master = source/consumer side, slave = demodulator side.
// -----------------------------------------------------------------------------
interface pwm_demod_if
  import pwm_demod_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
);

  logic             pwm_in;
  logic [WIDTH-1:0] sample_out;
  logic             sample_valid;
  logic             locked;
  logic             frame_err;

  modport master (
    output pwm_in,
    input  sample_out,
    input  sample_valid,
    input  locked,
    input  frame_err
  );

  modport slave (
    input  pwm_in,
    output sample_out,
    output sample_valid,
    output locked,
    output frame_err
  );

endinterface

// File: rtl/pwm_demod_sync_edge.sv
// -----------------------------------------------------------------------------
// pwm_demod_sync_edge
// Multi-flop synchronizer for an asynchronous pin followed by a rising-edge
// detector. Reusable for any slow asynchronous input.
//   clk    : system clock
//   rst_n  : synchronous active-low reset (clears all flops)
//   pin    : asynchronous input
//   pin_s  : synchronized level (last synchronizer stage)
//   rise   : pin_s high while its one-cycle-delayed copy is low
// Parameter STAGES (>= 2) sets the synchronizer depth.
// -----------------------------------------------------------------------------
module pwm_demod_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic pin_s,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              pin_d_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      pin_d_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[STAGES-2:0], pin};
      pin_d_reg <= sync_reg[STAGES-1];
    end
  end

  assign pin_s = sync_reg[STAGES-1];
  assign rise  = sync_reg[STAGES-1] & ~pin_d_reg;

endmodule

// File: rtl/pwm_demod.sv
// -----------------------------------------------------------------------------
// pwm_demod
// Receive side of the audio PWM link. Recovers the sample carried by a
// fixed-period PWM stream (high time = sample value). Frames are delimited by
// rising edges of the synchronized pin, or by a period timeout when no edge
// arrives (constant-level input). One sample is emitted per frame.
//   clk          : system clock (only clock)
//   rst_n        : synchronous active-low reset
//   bus (slave)  : pwm_in in; sample_out, sample_valid, locked, frame_err out
// Parameters: PERIOD (clocks per frame), WIDTH (sample width, must equal the
// interface WIDTH), SYNC_STAGES (synchronizer depth, >= 2).
// Optional build macro PWM_DEMOD_FRAME_CHECK_EN: when defined, a rising edge
// that arrives in LOCKED before a full period has elapsed pulses frame_err
// together with the sample_valid of that (short) frame. When undefined,
// frame_err is tied low.
// -----------------------------------------------------------------------------
module pwm_demod
  import pwm_demod_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int WIDTH       = SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  pwm_demod_if.slave bus
);

  localparam int              CW       = $clog2(PERIOD + 1);
  localparam logic [CW-1:0]   PERIOD_C = CW'(PERIOD);
  localparam int unsigned     SAT      = sat_max(WIDTH);

  logic pin_s;
  logic rise;

  pwm_demod_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .pin  (bus.pwm_in),
    .pin_s(pin_s),
    .rise (rise)
  );

  state_t           state_reg;
  state_t           state_next;
  logic [CW-1:0]    period_cnt_reg;
  logic [CW-1:0]    high_cnt_reg;
  logic [WIDTH-1:0] sample_reg;
  logic [WIDTH-1:0] sample_next;
  logic             valid_reg;
  logic             at_period;
  logic             boundary;
  logic             const_frame;
  logic             emit;

  // A rise and a timeout landing on the same cycle form a single boundary.
  always_comb begin
    at_period   = (period_cnt_reg == PERIOD_C);
    boundary    = rise | at_period;
    const_frame = (high_cnt_reg == PERIOD_C) || (high_cnt_reg == '0);
    sample_next = (32'(high_cnt_reg) > SAT) ? WIDTH'(SAT) : WIDTH'(high_cnt_reg);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ACQUIRE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: the first boundary after reset establishes alignment.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACQUIRE: if (boundary) state_next = LOCKED;
      LOCKED:  state_next = LOCKED;
      default: state_next = ACQUIRE;
    endcase
  end

  // Outputs: while acquiring, the frame before the first boundary is usually
  // partial and is dropped. The exception is an edge-less timeout over a
  // constant level, which is necessarily a complete frame.
  always_comb begin
    emit = 1'b0;
    case (state_reg)
      ACQUIRE: emit = at_period & ~rise & const_frame;
      LOCKED:  emit = boundary;
      default: emit = 1'b0;
    endcase
  end

  // The boundary cycle itself is the first cycle of the new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt_reg <= '0;
      high_cnt_reg   <= '0;
    end else if (boundary) begin
      period_cnt_reg <= CW'(1);
      high_cnt_reg   <= CW'(pin_s);
    end else begin
      period_cnt_reg <= period_cnt_reg + CW'(1);
      high_cnt_reg   <= high_cnt_reg + CW'(pin_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= emit;
      if (emit) sample_reg <= sample_next;
    end
  end

`ifdef PWM_DEMOD_FRAME_CHECK_EN
  logic err_reg;

  // Only edges can shorten a frame; timeouts are full length by construction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= (state_reg == LOCKED) & rise & ~at_period;
    end
  end

  assign bus.frame_err = err_reg;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.sample_out   = sample_reg;
  assign bus.sample_valid = valid_reg;
  assign bus.locked       = (state_reg == LOCKED);

endmodule

// File: tb/tb_pwm_demod.sv
// -----------------------------------------------------------------------------
// tb_pwm_demod
// Self-checking bench for pwm_demod. A PWM transmitter drives the pin; a
// reference model works on the recorded history of the synchronized pin:
// a frame closes on a rising edge or after PERIOD clocks, and its sample is
// the number of high cycles in the window since the previous boundary.
// Respects PWM_DEMOD_FRAME_CHECK_EN for the frame_err expectation.
// -----------------------------------------------------------------------------
module tb_pwm_demod;
  import pwm_demod_pkg::*;

  localparam int P = PWM_PERIOD;
  localparam int S = 2;
`ifdef PWM_DEMOD_FRAME_CHECK_EN
  localparam int GLITCH_ERRS = 2;
`else
  localparam int GLITCH_ERRS = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_demod_if #(.WIDTH(SAMPLE_W)) bus ();

  pwm_demod #(
    .PERIOD(P),
    .WIDTH(SAMPLE_W),
    .SYNC_STAGES(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state. Index k counts clock edges since the last reset edge.
  int samp_q[$];   // pwm_in captured at edge k
  int ps_q[$];     // synchronized level seen at edge k
  int k;
  int last_b;      // edge index at which the current frame began
  bit m_locked;
  int m_sample;
  bit m_valid;
  bit m_err;

  int dut_first_valid;
  int seg_valids;
  int seg_errs;

  typedef struct {
    int sample;
    int frames;
    int glitch_c;
    int exp_last;
    int exp_valids;
    int exp_errs;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t k=%0d: got %0d, expected %0d", name, $time, k, act, exp);
  endtask

  task automatic model_reset();
    samp_q.delete();
    ps_q.delete();
    samp_q.push_back(0);
    ps_q.push_back(0);
    k        = 0;
    last_b   = 1;
    m_locked = 1'b0;
    m_sample = 0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input bit pin);
    int  ps_k;
    int  sum;
    bit  rise;
    bit  at_p;
    bit  emit;
    k++;
    samp_q.push_back(int'(pin));
    ps_k = (k - S >= 1) ? samp_q[k-S] : 0;
    ps_q.push_back(ps_k);
    rise    = (ps_k == 1) && (ps_q[k-1] == 0);
    at_p    = (k - last_b) == P;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rise || at_p) begin
      sum = 0;
      for (int j = last_b; j < k; j++) sum += ps_q[j];
      emit = m_locked || (!rise && (sum == 0 || sum == P));
      if (emit) begin
        m_valid  = 1'b1;
        m_sample = (sum > 255) ? 255 : sum;
      end
`ifdef PWM_DEMOD_FRAME_CHECK_EN
      m_err = m_locked && rise && !at_p;
`endif
      m_locked = 1'b1;
      last_b   = k;
    end
  endtask

  task automatic tick(input bit pin, input bit do_rst);
    bus.pwm_in = pin;
    rst_n      = !do_rst;
    @(posedge clk);
    #1;
    if (do_rst) model_reset();
    else model_step(pin);
    check("valid", int'(bus.sample_valid), int'(m_valid));
    check("sample", int'(bus.sample_out), m_sample);
    check("locked", int'(bus.locked), int'(m_locked));
    check("frame_err", int'(bus.frame_err), int'(m_err));
    if (bus.sample_valid) seg_valids++;
    if (bus.frame_err) seg_errs++;
    if (bus.sample_valid && dut_first_valid < 0) dut_first_valid = k;
    if (m_valid) $display("sample k=%0d value=%0d err=%0d", k, m_sample, m_err);
  endtask

  // Transmitter: high for the first 'sample' clocks of each frame. Optional
  // 3-clock runt pulse in the first frame, optional one-clock reset.
  task automatic run_seg(input int sample, input int frames, input int glitch_c,
                         input int rst_f, input int rst_c);
    bit pin;
    bit r;
    for (int f = 0; f < frames; f++) begin
      for (int c = 0; c < P; c++) begin
        pin = (c < sample);
        if (f == 0 && glitch_c >= 0 && c >= glitch_c && c < glitch_c + 3) pin = 1'b1;
        r = (f == rst_f) && (c == rst_c);
        tick(pin, r);
        if (r) begin
          check("rst_sample", int'(bus.sample_out), 0);
          check("rst_locked", int'(bus.locked), 0);
          check("rst_valid", int'(bus.sample_valid), 0);
          seg_valids = 0;
        end
      end
    end
  endtask

  initial begin
    int smp;
    int gl;
    int rf;
    int rc;
    int nf;

    vecs[0]  = '{0,   3, -1, 0,   3, 0};
    vecs[1]  = '{255, 3, -1, 255, 3, 0};
    vecs[2]  = '{100, 4, -1, 100, 4, 0};
    vecs[3]  = '{1,   1, -1, 100, 1, 0};
    vecs[4]  = '{128, 1, -1, 1,   1, 0};
    vecs[5]  = '{254, 1, -1, 128, 1, 0};
    vecs[6]  = '{60,  2, -1, 60,  2, 0};
    vecs[7]  = '{40,  3, 100, 40, 4, GLITCH_ERRS};
    vecs[8]  = '{40,  2, -1, 40,  2, 0};
    vecs[9]  = '{255, 2, -1, 255, 2, 0};
    vecs[10] = '{0,   2, -1, 0,   2, 0};
    vecs[11] = '{255, 2, -1, 255, 2, 0};

    bus.pwm_in      = 1'b0;
    dut_first_valid = -1;
    seg_valids      = 0;
    seg_errs        = 0;
    model_reset();

    // Reset state.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    check("reset_sample", int'(bus.sample_out), 0);
    check("reset_locked", int'(bus.locked), 0);
    check("reset_err", int'(bus.frame_err), 0);

    // Constant low from reset release: timeout frames yielding 0.
    dut_first_valid = -1;
    seg_valids      = 0;
    run_seg(0, 3, -1, -1, -1);
    check("lo_latency", int'(dut_first_valid > 0 && dut_first_valid <= P + S + 1), 1);
    check("lo_locked", int'(bus.locked), 1);
    check("lo_valids", seg_valids, 2);

    // Constant high from reset release: first valid within P+S+1 clocks.
    tick(1'b0, 1'b1);
    dut_first_valid = -1;
    seg_valids      = 0;
    run_seg(255, 3, -1, -1, -1);
    check("hi_latency", int'(dut_first_valid > 0 && dut_first_valid <= P + S + 1), 1);
    check("hi_last", int'(bus.sample_out), 255);
    check("hi_valids", seg_valids, 2);

    // Table-driven frame sequences on a continuous aligned stream.
    for (int v = 0; v < 12; v++) begin
      seg_valids = 0;
      seg_errs   = 0;
      run_seg(vecs[v].sample, vecs[v].frames, vecs[v].glitch_c, -1, -1);
      check($sformatf("vec%0d_last", v), int'(bus.sample_out), vecs[v].exp_last);
      check($sformatf("vec%0d_valids", v), seg_valids, vecs[v].exp_valids);
      check($sformatf("vec%0d_errs", v), seg_errs, vecs[v].exp_errs);
    end

    // One-clock reset mid-frame at sample 60 (pin low at that point).
    run_seg(60, 2, -1, 1, 150);
    check("rst_no_partial", seg_valids, 0);
    seg_valids = 0;
    run_seg(60, 3, -1, -1, -1);
    check("rst_after_valids", seg_valids, 2);
    check("rst_after_sample", int'(bus.sample_out), 60);
    check("rst_after_locked", int'(bus.locked), 1);

    // Randomized frames, runts and resets against the model.
    for (int i = 0; i < 40; i++) begin
      smp = int'($urandom_range(0, 255));
      gl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, P - 4)) : -1;
      rf  = ($urandom_range(0, 9) == 0) ? 0 : -1;
      rc  = int'($urandom_range(0, P - 1));
      nf  = int'($urandom_range(1, 2));
      run_seg(smp, nf, gl, rf, rc);
    end

    // Random pin noise: many runt frames.
    for (int i = 0; i < 600; i++) tick(1'($urandom_range(0, 1)), 1'b0);
    run_seg(0, 2, -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
